scalar_product_mac: RTL and testbench
=====================================

Name: scalar_product_mac

Overview:
- Sequential multiply-accumulate unit that computes the dot product of two packed vectors A and B.
- Each vector holds Ndata unsigned elements of Nbits each.
- Processes one element pair per clock, starting when reset deasserts, and accumulates into a 2*Nbits result register.
- Leaf arithmetic block in the matmul datapath, instantiated per output cell of the matrix product.

Parameters:
- Nbits, 4: width of each unsigned element of A and B.
- Ndata, 4: number of elements per vector (>=1).

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset; clears state and restarts the computation.
- A  input  Ndata*Nbits  packed vector; element k = A[k*Nbits +: Nbits], unsigned.
- B  input  Ndata*Nbits  packed vector; element k = B[k*Nbits +: Nbits], unsigned.
- out  output  2*Nbits  registered accumulator = running or final dot product.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Internal state: element index counter idx, range 0..Ndata; accumulator acc, 2*Nbits bits.
  - out is driven directly from acc; no combinational path from A/B to out.
- Reset:
  - On any rising edge with reset=1: idx<=0, acc<=0. out reads 0 from the following cycle.
  - Reset has priority over accumulation on the same edge.
  - Holding reset for multiple cycles keeps out=0 and idx=0.
- Accumulate:
  - On each rising edge with reset=0 and idx<Ndata: acc <= acc + A[idx]*B[idx], idx <= idx+1.
  - The product is unsigned Nbits x Nbits -> 2*Nbits.
- Arithmetic:
  - Unsigned throughout.
  - Sum truncated modulo 2^(2*Nbits): overflow wraps silently, no saturation, no flag.
- Latency:
  - After the first edge with reset=0, out holds the partial sum of element 0.
  - After Ndata edges, out holds the final dot product (4 cycles for the defaults).
  - Intermediate partial sums are visible on out during accumulation.
- Hold:
  - Once idx=Ndata, acc and idx freeze.
  - out holds the final value indefinitely until the next reset, even if A/B change.
- Input stability:
  - A and B are sampled element-by-element on each accumulate edge.
  - A and B must remain stable from reset deassertion until idx=Ndata.
  - Changes before completion affect only elements not yet consumed.
- Reset mid-operation: clears acc and idx on that edge. Accumulation restarts from element 0 once reset deasserts.
- Element order: element 0 first, ascending. Ordering does not affect the result.
- Counter width: $clog2(Ndata+1) bits, so idx can reach Ndata without wrapping.

Test Plan (Nbits=4, Ndata=4):
- Reset hold: reset=1 for 2 cycles with A=16'hFFFF, B=16'hFFFF -> out=8'h00 throughout.
- Basic dot product, partial sums: A=16'h1234, B=16'h1111, release reset -> out sequence 8'h04, 8'h07, 8'h09, 8'h0A. Final 8'h0A holds for 10+ cycles.
- Overflow wrap: A=16'hFFFF, B=16'hFFFF -> 4*225=900 mod 256 -> out=8'h84 after 4 cycles.
- Zero/single element: A=16'h0001, B=16'h0003 -> out=8'h03 after first edge and stays 8'h03. A=16'h0000 with any B -> 8'h00.
- Reset mid-operation and hold: A=16'h1234, B=16'h1111; assert reset after 2 accumulate edges -> out=8'h00 next cycle. Deassert -> final 8'h0A. After completion, change A to 16'hFFFF -> out remains 8'h0A.
- Randomized regression: 100 random A/B pairs, each run as reset for 2 cycles, then 10 cycles with reset=0 -> out equals sum of A[k]*B[k] mod 256, zero mismatches.

Source files
------------

// File: rtl/scalar_product_mac.sv
// -----------------------------------------------------------------------------
// scalar_product_mac
//
// Sequential multiply-accumulate unit that forms the dot product of two packed
// unsigned vectors, one element pair per clock. It starts from element 0 on the
// first edge after reset deasserts and then walks upward. When all Ndata
// elements have been consumed, the accumulator freezes until the next reset.
// The sum wraps modulo 2^(2*Nbits).
//
// Parameters
//   Nbits : width of each unsigned element of A and B
//   Ndata : number of elements per vector (>= 1)
//
// Ports
//   clk   : system clock; all state updates on its rising edge
//   reset : synchronous, active-high; clears idx/acc and restarts the product
//   A     : packed vector, element k = A[k*Nbits +: Nbits]
//   B     : packed vector, element k = B[k*Nbits +: Nbits]
//   out   : registered accumulator (running or final dot product)
// -----------------------------------------------------------------------------
module scalar_product_mac #(
  parameter int Nbits = 4,
  parameter int Ndata = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [Ndata*Nbits-1:0] A,
  input  logic [Ndata*Nbits-1:0] B,
  output logic [2*Nbits-1:0]     out
);

  // Counter must reach Ndata itself, so it needs one more state than Ndata.
  localparam int CW = $clog2(Ndata + 1);
  localparam int PW = 2 * Nbits;
  localparam logic [CW-1:0] LAST_IDX = CW'(Ndata);

  logic [CW-1:0]    idx_q, idx_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [Nbits-1:0] a_sel, b_sel;
  logic [PW-1:0]    prod;
  logic             busy;

  // Unsigned add that silently wraps modulo 2^PW (no saturation, no flag).
  function automatic logic [PW-1:0] wrap_add(input logic [PW-1:0] x,
                                             input logic [PW-1:0] y);
    logic [PW:0] full;
    full = {1'b0, x} + {1'b0, y};
    return full[PW-1:0];
  endfunction

  // Element select by index. The select is built as a mux over constant
  // slices, so idx == Ndata never produces an out-of-range part-select; in
  // that state the selected value is unused anyway.
  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < Ndata; k++) begin
      if (idx_q == CW'(k)) begin
        a_sel = A[k*Nbits +: Nbits];
        b_sel = B[k*Nbits +: Nbits];
      end
    end
  end

  // Zero-extend both operands so the product is a full-width unsigned result.
  assign prod = {{Nbits{1'b0}}, a_sel} * {{Nbits{1'b0}}, b_sel};
  assign busy = (idx_q < LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (busy) begin
      idx_d = idx_q + 1'b1;
      acc_d = wrap_add(acc_q, prod);
    end
  end

  // State register: reset takes priority over accumulation on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  assign out = acc_q;

endmodule

// File: tb/tb_scalar_product_mac.sv
module tb_scalar_product_mac;

  localparam int NB = 4;
  localparam int ND = 4;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic [ND*NB-1:0] A = '0;
  logic [ND*NB-1:0] B = '0;
  logic [2*NB-1:0]  out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2*NB-1:0] sb_q[$];

  scalar_product_mac #(.Nbits(NB), .Ndata(ND)) dut (
    .clk(clk), .reset(reset), .A(A), .B(B), .out(out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  final_exp;
  } vec_t;

  // Reference: sum of the first n element products, modulo 256.
  function automatic logic [7:0] model(input logic [15:0] a, input logic [15:0] b,
                                       input int n);
    int s;
    int ea, eb;
    s = 0;
    for (int k = 0; k < n && k < ND; k++) begin
      ea = int'((a >> (NB * k)) & 16'h000F);
      eb = int'((b >> (NB * k)) & 16'h000F);
      s = s + ea * eb;
    end
    return 8'(s % 256);
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Two reset cycles (checked), then `cycles` accumulate edges checked
  // through the scoreboard against the model.
  task automatic run_vec(input string name, input logic [15:0] a, input logic [15:0] b,
                         input int cycles);
    logic [7:0] e;
    A = a;
    B = b;
    reset = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check({name, "_reset"}, out, 8'h00);
    end
    reset = 1'b0;
    for (int c = 1; c <= cycles; c++) begin
      sb_q.push_back(model(a, b, c));
      tick();
      if (sb_q.size() == 0) begin
        check({name, "_sb_empty"}, 8'hXX, 8'h00);
      end else begin
        e = sb_q.pop_front();
        check(name, out, e);
      end
    end
  endtask

  initial begin
    vec_t vt[6];
    vt[0] = '{16'h1234, 16'h1111, 8'h0A};
    vt[1] = '{16'hFFFF, 16'hFFFF, 8'h84};
    vt[2] = '{16'h0001, 16'h0003, 8'h03};
    vt[3] = '{16'h0000, 16'hABCD, 8'h00};
    vt[4] = '{16'h2222, 16'h3333, 8'h18};
    vt[5] = '{16'h00F0, 16'h00F0, 8'hE1};

    // Reset hold with all-ones inputs.
    A = 16'hFFFF;
    B = 16'hFFFF;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", out, 8'h00);
    end

    // Basic partial sums, explicit sequence.
    A = 16'h1234;
    B = 16'h1111;
    reset = 1'b0;
    tick(); check("basic_p0", out, 8'h04);
    tick(); check("basic_p1", out, 8'h07);
    tick(); check("basic_p2", out, 8'h09);
    tick(); check("basic_p3", out, 8'h0A);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("basic_hold", out, 8'h0A);
    end

    // Table vectors: partial sums via scoreboard, plus constant final value.
    for (int i = 0; i < 6; i++) begin
      run_vec($sformatf("table%0d", i), vt[i].a, vt[i].b, 8);
      check($sformatf("table%0d_final", i), out, vt[i].final_exp);
    end

    // Single element: value appears after first edge and stays.
    A = 16'h0001;
    B = 16'h0003;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick(); check("single_first", out, 8'h03);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("single_stay", out, 8'h03);
    end

    // Reset mid-operation, then restart and hold against input change.
    A = 16'h1234;
    B = 16'h1111;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    tick(); check("mid_p0", out, 8'h04);
    tick(); check("mid_p1", out, 8'h07);
    reset = 1'b1;
    tick(); check("mid_reset", out, 8'h00);
    reset = 1'b0;
    tick(); check("mid_restart_p0", out, 8'h04);
    tick();
    tick();
    tick(); check("mid_final", out, 8'h0A);
    A = 16'hFFFF;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("mid_hold_after_change", out, 8'h0A);
    end

    // Randomized regression.
    for (int i = 0; i < 100; i++) begin
      logic [15:0] ra, rb;
      ra = 16'($urandom);
      rb = 16'($urandom);
      run_vec("random", ra, rb, 10);
    end

    if (sb_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d entries left, expected 0", sb_q.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
